// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg
// Shared types and widths for the mem_responder slice.
//   mode_t  : operation code carried with a transfer strobe
//   state_t : bus-responder FSM states
//   ADDR_W / DATA_W / MEM_DEPTH : storage geometry (256 x 8)
package mem_resp_pkg;

  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 8;
  localparam int MEM_DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    MODE_NOP   = 2'b00,
    MODE_READ  = 2'b01,
    MODE_WRITE = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/mem_array.sv
// mem_array
// 256 x 8 storage with a synchronous write port and a combinational read
// port. The contents are deliberately not reset so that an aborted
// transfer leaves previously written data intact.
//   clk     : write clock
//   wr_en   : write strobe, commits wr_data to wr_addr on the rising edge
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address
//   rd_data : combinational read data
module mem_array
  import mem_resp_pkg::*;
(
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mem_responder.sv
// mem_responder
// Single-initiator bus responder in front of a 256 x 8 memory. An
// initiator raises req, receives gnt, issues a one-cycle start with
// mode/addr/data_in, and after WAIT_STATES access cycles gets a one-cycle
// rdy pulse (with read data, or err for the reserved opcode).
//   clk      : clock, all state updates on rising edge
//   rst_n    : asynchronous active-low reset
//   req      : bus request
//   start    : transfer strobe, only honoured while gnt=1
//   mode     : 00 NOP, 01 READ, 10 WRITE, 11 reserved
//   addr     : byte address
//   data_in  : write data, sampled with start
//   gnt      : bus granted
//   rdy      : one-cycle completion pulse
//   data_out : read data, non-zero only on a READ completion
//   data_oe  : responder drives data (READ completion only)
//   err      : reserved-opcode completion flag, coincident with rdy
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int WAIT_STATES = 2,
  parameter int GNT_TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic              gnt,
  output logic              rdy,
  output logic [DATA_W-1:0] data_out,
  output logic              data_oe,
  output logic              err
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);
  // Timeout counter counts from 0, so the last granted cycle is at N-1.
  localparam logic [7:0] TO_LAST   = 8'(GNT_TIMEOUT - 1);

  state_t            state_reg, state_next;
  logic [3:0]        wcnt_reg, wcnt_next;
  logic [7:0]        tcnt_reg, tcnt_next;
  // Set when the grant times out; blocks regrant until req is seen low.
  logic              lock_reg, lock_next;
  mode_t             mode_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] data_reg;

  logic              capture;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic              in_done;

  // State register and captured transfer attributes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      wcnt_reg  <= '0;
      tcnt_reg  <= '0;
      lock_reg  <= 1'b0;
      mode_reg  <= MODE_NOP;
      addr_reg  <= '0;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      wcnt_reg  <= wcnt_next;
      tcnt_reg  <= tcnt_next;
      lock_reg  <= lock_next;
      if (capture) begin
        mode_reg <= mode_t'(mode);
        addr_reg <= addr;
        data_reg <= data_in;
      end
    end
  end

  // Next-state and memory-write decode.
  always_comb begin
    state_next = state_reg;
    wcnt_next  = wcnt_reg;
    tcnt_next  = tcnt_reg;
    lock_next  = lock_reg & req;
    capture    = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = addr_reg;
    wr_data    = data_reg;

    case (state_reg)
      IDLE: begin
        tcnt_next = '0;
        if (req && !lock_reg) begin
          state_next = GRANT;
        end
      end

      GRANT: begin
        if (start) begin
          capture   = 1'b1;
          tcnt_next = '0;
          if (WAIT_STATES == 0) begin
            // No access cycles: the write commits on the same edge that
            // samples start, so take address/data straight from the inputs.
            state_next = DONE;
            wcnt_next  = '0;
            wr_en      = (mode == MODE_WRITE);
            wr_addr    = addr;
            wr_data    = data_in;
          end else begin
            state_next = ACCESS;
            wcnt_next  = WAIT_INIT;
          end
        end else if (!req) begin
          state_next = IDLE;
          tcnt_next  = '0;
        end else if (tcnt_reg == TO_LAST) begin
          state_next = IDLE;
          tcnt_next  = '0;
          lock_next  = 1'b1;
        end else begin
          tcnt_next = tcnt_reg + 8'd1;
        end
      end

      ACCESS: begin
        if (wcnt_reg <= 4'd1) begin
          state_next = DONE;
          wcnt_next  = '0;
          wr_en      = (mode_reg == MODE_WRITE);
        end else begin
          wcnt_next = wcnt_reg - 4'd1;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  mem_array u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (addr_reg),
    .rd_data (rd_data)
  );

  // Outputs decode from registered state only, so the asynchronous reset
  // clears them without waiting for a clock edge.
  assign in_done  = (state_reg == DONE);
  assign gnt      = (state_reg == GRANT);
  assign rdy      = in_done;
  assign err      = in_done && (mode_reg == MODE_RSVD);
  assign data_oe  = in_done && (mode_reg == MODE_READ);
  assign data_out = data_oe ? rd_data : '0;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  logic       clk;
  // Instance a: default build (WAIT_STATES=2, GNT_TIMEOUT=8)
  logic       rst_n, req, start;
  logic [1:0] mode;
  logic [7:0] addr, data_in;
  logic       gnt, rdy, data_oe, err;
  logic [7:0] data_out;
  // Instance b: WAIT_STATES=0 build
  logic       rst_n_b, req_b, start_b;
  logic [1:0] mode_b;
  logic [7:0] addr_b, data_in_b;
  logic       gnt_b, rdy_b, data_oe_b, err_b;
  logic [7:0] data_out_b;

  int tests;
  int failed;

  mem_responder #(.WAIT_STATES(2), .GNT_TIMEOUT(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req), .start(start), .mode(mode),
    .addr(addr), .data_in(data_in), .gnt(gnt), .rdy(rdy),
    .data_out(data_out), .data_oe(data_oe), .err(err)
  );

  mem_responder #(.WAIT_STATES(0), .GNT_TIMEOUT(8)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .req(req_b), .start(start_b), .mode(mode_b),
    .addr(addr_b), .data_in(data_in_b), .gnt(gnt_b), .rdy(rdy_b),
    .data_out(data_out_b), .data_oe(data_oe_b), .err(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Request, start one transfer on instance a and wait (bounded) for rdy.
  // Returns with the bench sitting in the rdy cycle.
  task automatic run_xfer(input logic [1:0] m, input logic [7:0] a,
                          input logic [7:0] d, input string tag);
    int lat;
    req = 1'b1;
    tick();
    chk({tag, "_gnt"}, gnt, 1);
    start = 1'b1; mode = m; addr = a; data_in = d;
    tick();
    start = 1'b0; req = 1'b0; mode = 2'b00; addr = 8'h00; data_in = 8'h00;
    lat = 1;
    while (rdy !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, 3);
    $display("[TB] xfer %s mode=%0d addr=%02h din=%02h lat=%0d rdy=%0b err=%0b oe=%0b dout=%02h",
             tag, m, a, d, lat, rdy, err, data_oe, data_out);
  endtask

  task automatic end_xfer(input string tag);
    tick();
    chk({tag, "_rdy_clear"}, rdy, 0);
    chk({tag, "_oe_clear"}, data_oe, 0);
    chk({tag, "_dout_clear"}, data_out, 0);
  endtask

  logic [1:0] b_mode [4];
  logic [7:0] b_addr [4];
  logic [7:0] b_din  [4];
  logic [7:0] b_dout [4];
  logic       b_oe   [4];

  initial begin
    int cnt;
    logic regrant;
    tests = 0; failed = 0;
    rst_n = 1'b0; req = 1'b0; start = 1'b0; mode = 2'b00; addr = 8'h00; data_in = 8'h00;
    rst_n_b = 1'b0; req_b = 1'b0; start_b = 1'b0; mode_b = 2'b00; addr_b = 8'h00; data_in_b = 8'h00;

    // Reset state
    repeat (2) tick();
    chk("rst_gnt", gnt, 0);
    chk("rst_rdy", rdy, 0);
    chk("rst_err", err, 0);
    chk("rst_oe", data_oe, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_gnt_b", gnt_b, 0);
    rst_n = 1'b1; rst_n_b = 1'b1;
    tick();
    chk("idle_gnt", gnt, 0);

    // WRITE 0x3C <= 0xA5, then READ it back
    run_xfer(2'b10, 8'h3C, 8'hA5, "wr3c");
    chk("wr3c_rdy", rdy, 1);
    chk("wr3c_oe", data_oe, 0);
    chk("wr3c_err", err, 0);
    chk("wr3c_dout", data_out, 0);
    end_xfer("wr3c");

    run_xfer(2'b01, 8'h3C, 8'h00, "rd3c");
    chk("rd3c_rdy", rdy, 1);
    chk("rd3c_oe", data_oe, 1);
    chk("rd3c_dout", data_out, 8'hA5);
    chk("rd3c_err", err, 0);
    end_xfer("rd3c");

    // NOP must not touch memory
    run_xfer(2'b00, 8'h3C, 8'hFF, "nop");
    chk("nop_rdy", rdy, 1);
    chk("nop_oe", data_oe, 0);
    chk("nop_err", err, 0);
    end_xfer("nop");
    run_xfer(2'b01, 8'h3C, 8'h00, "rd3c_after_nop");
    chk("rd3c_after_nop_dout", data_out, 8'hA5);
    end_xfer("rd3c_after_nop");

    // Grant timeout: gnt high for exactly 8 cycles, no regrant while req held
    req = 1'b1;
    tick();
    cnt = 0;
    while (gnt === 1'b1 && cnt < 30) begin
      cnt++;
      tick();
    end
    chk("timeout_gnt_cycles", cnt, 8);
    regrant = 1'b0;
    repeat (5) begin
      tick();
      if (gnt !== 1'b0) regrant = 1'b1;
    end
    chk("timeout_no_regrant", regrant, 0);
    req = 1'b0;
    tick();
    req = 1'b1;
    tick();
    chk("timeout_regrant_after_toggle", gnt, 1);
    req = 1'b0;
    tick();
    chk("release_gnt", gnt, 0);
    $display("[TB] xfer timeout gnt_cycles=%0d regrant_while_held=%0b", cnt, regrant);

    // Reserved opcode: err with rdy, memory unchanged
    run_xfer(2'b10, 8'h10, 8'h5A, "wr10");
    end_xfer("wr10");
    run_xfer(2'b11, 8'h10, 8'h77, "rsvd");
    chk("rsvd_rdy", rdy, 1);
    chk("rsvd_err", err, 1);
    chk("rsvd_oe", data_oe, 0);
    end_xfer("rsvd");
    chk("rsvd_err_clear", err, 0);
    run_xfer(2'b01, 8'h10, 8'h00, "rd10");
    chk("rd10_dout", data_out, 8'h5A);
    end_xfer("rd10");

    // Asynchronous reset while granted: gnt drops before any clock edge
    req = 1'b1;
    tick();
    chk("pre_async_gnt", gnt, 1);
    #2 rst_n = 1'b0;
    #1 chk("async_gnt", gnt, 0);
    req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    $display("[TB] xfer async_reset_in_grant gnt=%0b", gnt);

    // Reset during ACCESS of WRITE 0x55 -> 0x20 aborts the write
    run_xfer(2'b10, 8'h20, 8'h11, "wr20");
    end_xfer("wr20");
    req = 1'b1;
    tick();
    start = 1'b1; mode = 2'b10; addr = 8'h20; data_in = 8'h55;
    tick();
    start = 1'b0; req = 1'b0; mode = 2'b00; addr = 8'h00; data_in = 8'h00;
    chk("access_gnt", gnt, 0);
    rst_n = 1'b0;
    #1;
    chk("abort_gnt", gnt, 0);
    chk("abort_rdy", rdy, 0);
    chk("abort_err", err, 0);
    chk("abort_oe", data_oe, 0);
    chk("abort_dout", data_out, 0);
    repeat (3) tick();
    chk("abort_held_rdy", rdy, 0);
    rst_n = 1'b1;
    tick();
    $display("[TB] xfer abort_write addr=20 din=55");
    run_xfer(2'b01, 8'h20, 8'h00, "rd20");
    chk("rd20_dout", data_out, 8'h11);
    chk("rd20_oe", data_oe, 1);
    end_xfer("rd20");

    // WAIT_STATES=0 build, req held: rdy one cycle after start, one idle gap
    b_mode[0] = 2'b10; b_addr[0] = 8'h01; b_din[0] = 8'h3C; b_dout[0] = 8'h00; b_oe[0] = 1'b0;
    b_mode[1] = 2'b10; b_addr[1] = 8'h02; b_din[1] = 8'hC3; b_dout[1] = 8'h00; b_oe[1] = 1'b0;
    b_mode[2] = 2'b01; b_addr[2] = 8'h02; b_din[2] = 8'h00; b_dout[2] = 8'hC3; b_oe[2] = 1'b1;
    b_mode[3] = 2'b01; b_addr[3] = 8'h01; b_din[3] = 8'h00; b_dout[3] = 8'h3C; b_oe[3] = 1'b1;
    req_b = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("b_gnt", gnt_b, 1);
      start_b = 1'b1; mode_b = b_mode[i]; addr_b = b_addr[i]; data_in_b = b_din[i];
      tick();
      start_b = 1'b0; mode_b = 2'b00; addr_b = 8'h00; data_in_b = 8'h00;
      chk("b_rdy", rdy_b, 1);
      chk("b_oe", data_oe_b, b_oe[i]);
      chk("b_dout", data_out_b, b_dout[i]);
      chk("b_err", err_b, 0);
      $display("[TB] xfer b%0d mode=%0d addr=%02h din=%02h rdy=%0b oe=%0b dout=%02h",
               i, b_mode[i], b_addr[i], b_din[i], rdy_b, data_oe_b, data_out_b);
      tick();
      chk("b_idle_gnt", gnt_b, 0);
      chk("b_idle_rdy", rdy_b, 0);
      tick();
    end
    req_b = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
